// File: rtl/cpu_6502_operand_fetch.sv
// cpu_6502_operand_fetch -- 6502 operand fetch and effective-address unit.
//
// Purpose: once the IR decoder has classified an instruction, this block
// fetches its operand bytes over a simple single-cycle read bus. It resolves
// every 6502 addressing mode to an effective address, an immediate/relative
// byte and the PC value past the operand.
//
// Ports:
//   i_clk           clock; all state changes on its rising edge
//   i_reset         synchronous active-high reset (takes priority over start)
//   i_start         begin a fetch; accepted only while o_busy = 0
//   i_operand_type  addressing mode (operand_type_t)
//   i_pc            address of the first operand byte
//   i_x, i_y        index registers, sampled with i_start
//   i_mem_data      read data, valid at the end of a cycle with o_mem_rd = 1
//   o_mem_addr      bus address (0 while no read is issued)
//   o_mem_rd        bus read strobe
//   o_busy          1 in every state except IDLE
//   o_done          one-cycle completion pulse
//   o_ea            effective address
//   o_operand       immediate/relative byte
//   o_pc_next       PC past the operand
//   o_page_cross    indexed add carried into the high byte
//
// Result outputs hold their values from o_done until the next accepted start.

package cpu_6502_operand_fetch_pkg;
  typedef enum logic [3:0] {
    IMPLIED          = 4'd0,
    ACCUMULATOR      = 4'd1,
    IMMEDIATE        = 4'd2,
    RELATIVE         = 4'd3,
    ZP               = 4'd4,
    ZP_X             = 4'd5,
    ZP_Y             = 4'd6,
    ABSOLUTE         = 4'd7,
    ABSOLUTE_X       = 4'd8,
    ABSOLUTE_Y       = 4'd9,
    INDIRECT         = 4'd10,
    INDEX_X_INDIRECT = 4'd11,
    INDEX_Y_INDIRECT = 4'd12
  } operand_type_t;
endpackage

module cpu_6502_operand_fetch
  import cpu_6502_operand_fetch_pkg::*;
#(
  parameter int PAGE_PENALTY = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  operand_type_t i_operand_type,
  input  logic [15:0]   i_pc,
  input  logic [7:0]    i_x,
  input  logic [7:0]    i_y,
  input  logic [7:0]    i_mem_data,
  output logic [15:0]   o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_busy,
  output logic          o_done,
  output logic [15:0]   o_ea,
  output logic [7:0]    o_operand,
  output logic [15:0]   o_pc_next,
  output logic          o_page_cross
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPR_LO = 3'd1,
    OPR_HI = 3'd2,
    PTR_LO = 3'd3,
    PTR_HI = 3'd4,
    FIXUP  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Indexed 16-bit add with wrap; bit 16 of the result is the carry out of
  // bit 7 (the page-crossing indication), bits 15:0 are the wrapped sum.
  function automatic logic [16:0] index_add(input logic [15:0] base, input logic [7:0] idx);
    logic [8:0]  lo_sum;
    logic [15:0] sum;
    lo_sum = {1'b0, base[7:0]} + {1'b0, idx};
    sum    = base + {8'h00, idx};
    return {lo_sum[8], sum};
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  operand_type_t type_r;
  logic [15:0]   pc_r;
  logic [7:0]    x_r;
  logic [7:0]    y_r;
  logic [7:0]    lo_r;
  logic [7:0]    lo_next_s;
  logic [15:0]   ptr_r;
  logic [15:0]   ptr_next_s;

  logic [15:0]   ea_r;
  logic [7:0]    operand_r;
  logic [15:0]   pc_next_r;
  logic          page_cross_r;
  logic          busy_r;
  logic          done_r;

  logic          load_out_s;
  logic [15:0]   ea_s;
  logic [7:0]    operand_s;
  logic [15:0]   pc_next_s;
  logic          page_cross_s;
  logic [15:0]   mem_addr_s;
  logic          mem_rd_s;
  logic [7:0]    idx_s;
  logic [16:0]   idx_sum_s;
  logic          accept_s;

  assign accept_s = (state_r == IDLE) && i_start;

  // ABSOLUTE_X is the only final-add mode that uses X; ABSOLUTE_Y and
  // INDEX_Y_INDIRECT both add Y. The base high byte is the byte arriving now.
  assign idx_s     = (type_r == ABSOLUTE_X) ? x_r : y_r;
  assign idx_sum_s = index_add({i_mem_data, lo_r}, idx_s);

  // Next-state, bus request and result computation.
  always_comb begin
    state_next_s = state_r;
    lo_next_s    = lo_r;
    ptr_next_s   = ptr_r;
    load_out_s   = 1'b0;
    ea_s         = 16'h0000;
    operand_s    = 8'h00;
    pc_next_s    = pc_r;
    page_cross_s = 1'b0;
    mem_addr_s   = 16'h0000;
    mem_rd_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (i_start) begin
          case (i_operand_type)
            IMMEDIATE, RELATIVE, ZP, ZP_X, ZP_Y, ABSOLUTE, ABSOLUTE_X,
            ABSOLUTE_Y, INDIRECT, INDEX_X_INDIRECT, INDEX_Y_INDIRECT: begin
              state_next_s = OPR_LO;
            end
            default: begin
              // IMPLIED, ACCUMULATOR and any undefined code: no bus traffic.
              state_next_s = DONE;
              load_out_s   = 1'b1;
              pc_next_s    = i_pc;
            end
          endcase
        end else begin
          state_next_s = IDLE;
        end
      end

      OPR_LO: begin
        mem_rd_s   = 1'b1;
        mem_addr_s = pc_r;
        case (type_r)
          IMMEDIATE, RELATIVE: begin
            state_next_s = DONE;
            load_out_s   = 1'b1;
            operand_s    = i_mem_data;
            ea_s         = pc_r;
            pc_next_s    = pc_r + 16'd1;
          end
          ZP, ZP_X, ZP_Y: begin
            state_next_s = DONE;
            load_out_s   = 1'b1;
            pc_next_s    = pc_r + 16'd1;
            // Zero-page indexing wraps inside page zero.
            if (type_r == ZP_X) begin
              ea_s = {8'h00, i_mem_data + x_r};
            end else if (type_r == ZP_Y) begin
              ea_s = {8'h00, i_mem_data + y_r};
            end else begin
              ea_s = {8'h00, i_mem_data};
            end
          end
          ABSOLUTE, ABSOLUTE_X, ABSOLUTE_Y: begin
            state_next_s = OPR_HI;
            lo_next_s    = i_mem_data;
          end
          INDIRECT: begin
            state_next_s = OPR_HI;
            ptr_next_s   = {ptr_r[15:8], i_mem_data};
          end
          INDEX_X_INDIRECT: begin
            state_next_s = PTR_LO;
            ptr_next_s   = {8'h00, i_mem_data + x_r};
          end
          INDEX_Y_INDIRECT: begin
            state_next_s = PTR_LO;
            ptr_next_s   = {8'h00, i_mem_data};
          end
          default: begin
            state_next_s = DONE;
            load_out_s   = 1'b1;
          end
        endcase
      end

      OPR_HI: begin
        mem_rd_s   = 1'b1;
        mem_addr_s = pc_r + 16'd1;
        case (type_r)
          ABSOLUTE: begin
            state_next_s = DONE;
            load_out_s   = 1'b1;
            ea_s         = {i_mem_data, lo_r};
            pc_next_s    = pc_r + 16'd2;
          end
          ABSOLUTE_X, ABSOLUTE_Y: begin
            load_out_s   = 1'b1;
            ea_s         = idx_sum_s[15:0];
            page_cross_s = idx_sum_s[16];
            pc_next_s    = pc_r + 16'd2;
            if ((PAGE_PENALTY != 0) && idx_sum_s[16]) begin
              state_next_s = FIXUP;
            end else begin
              state_next_s = DONE;
            end
          end
          INDIRECT: begin
            state_next_s = PTR_LO;
            ptr_next_s   = {i_mem_data, ptr_r[7:0]};
          end
          default: begin
            state_next_s = DONE;
            load_out_s   = 1'b1;
          end
        endcase
      end

      PTR_LO: begin
        mem_rd_s     = 1'b1;
        mem_addr_s   = ptr_r;
        lo_next_s    = i_mem_data;
        state_next_s = PTR_HI;
      end

      PTR_HI: begin
        mem_rd_s   = 1'b1;
        // Pointer increment stays within its page (NMOS behaviour, and the
        // zero-page wrap for the indexed-indirect modes).
        mem_addr_s = {ptr_r[15:8], ptr_r[7:0] + 8'd1};
        load_out_s = 1'b1;
        case (type_r)
          INDIRECT: begin
            state_next_s = DONE;
            ea_s         = {i_mem_data, lo_r};
            pc_next_s    = pc_r + 16'd2;
          end
          INDEX_X_INDIRECT: begin
            state_next_s = DONE;
            ea_s         = {i_mem_data, lo_r};
            pc_next_s    = pc_r + 16'd1;
          end
          INDEX_Y_INDIRECT: begin
            ea_s         = idx_sum_s[15:0];
            page_cross_s = idx_sum_s[16];
            pc_next_s    = pc_r + 16'd1;
            if ((PAGE_PENALTY != 0) && idx_sum_s[16]) begin
              state_next_s = FIXUP;
            end else begin
              state_next_s = DONE;
            end
          end
          default: begin
            state_next_s = DONE;
          end
        endcase
      end

      FIXUP: begin
        state_next_s = DONE;
      end

      DONE: begin
        state_next_s = IDLE;
      end

      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, working registers and held results.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r      <= IDLE;
      type_r       <= IMPLIED;
      pc_r         <= 16'h0000;
      x_r          <= 8'h00;
      y_r          <= 8'h00;
      lo_r         <= 8'h00;
      ptr_r        <= 16'h0000;
      ea_r         <= 16'h0000;
      operand_r    <= 8'h00;
      pc_next_r    <= 16'h0000;
      page_cross_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      lo_r    <= lo_next_s;
      ptr_r   <= ptr_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
      if (accept_s) begin
        type_r <= i_operand_type;
        pc_r   <= i_pc;
        x_r    <= i_x;
        y_r    <= i_y;
      end else begin
        type_r <= type_r;
        pc_r   <= pc_r;
        x_r    <= x_r;
        y_r    <= y_r;
      end
      if (load_out_s) begin
        ea_r         <= ea_s;
        operand_r    <= operand_s;
        pc_next_r    <= pc_next_s;
        page_cross_r <= page_cross_s;
      end else begin
        ea_r         <= ea_r;
        operand_r    <= operand_r;
        pc_next_r    <= pc_next_r;
        page_cross_r <= page_cross_r;
      end
    end
  end

  // Bus address depends only on state and registered bytes, never on the
  // data arriving in the same cycle.
  assign o_mem_addr   = mem_addr_s;
  assign o_mem_rd     = mem_rd_s;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_ea         = ea_r;
  assign o_operand    = operand_r;
  assign o_pc_next    = pc_next_r;
  assign o_page_cross = page_cross_r;

endmodule

// File: tb/tb_cpu_6502_operand_fetch.sv
// tb_cpu_6502_operand_fetch -- directed self-checking bench.
// Two instances share a byte-wide memory model: dut_p1 (PAGE_PENALTY=1) and
// dut_p0 (PAGE_PENALTY=0). Both run every operation; dut_p0 is checked only
// where the penalty makes a difference.

module tb_cpu_6502_operand_fetch;
  import cpu_6502_operand_fetch_pkg::*;

  logic          clk;
  logic          rst;
  logic          start;
  operand_type_t op_type;
  logic [15:0]   pc;
  logic [7:0]    x;
  logic [7:0]    y;

  logic [7:0]    data1, data0;
  logic [15:0]   addr1, addr0;
  logic          rd1, rd0, busy1, busy0, done1, done0, pcx1, pcx0;
  logic [15:0]   ea1, ea0, pcn1, pcn0;
  logic [7:0]    opr1, opr0;

  logic [7:0]    mem [0:65535];

  int n_assert = 0;
  int n_fail   = 0;

  assign data1 = mem[addr1];
  assign data0 = mem[addr0];

  cpu_6502_operand_fetch #(.PAGE_PENALTY(1)) dut_p1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_operand_type(op_type),
    .i_pc(pc), .i_x(x), .i_y(y), .i_mem_data(data1),
    .o_mem_addr(addr1), .o_mem_rd(rd1), .o_busy(busy1), .o_done(done1),
    .o_ea(ea1), .o_operand(opr1), .o_pc_next(pcn1), .o_page_cross(pcx1)
  );

  cpu_6502_operand_fetch #(.PAGE_PENALTY(0)) dut_p0 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_operand_type(op_type),
    .i_pc(pc), .i_x(x), .i_y(y), .i_mem_data(data0),
    .o_mem_addr(addr0), .o_mem_rd(rd0), .o_busy(busy0), .o_done(done0),
    .o_ea(ea0), .o_operand(opr0), .o_pc_next(pcn0), .o_page_cross(pcx0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start (cycle 0); returns positioned in cycle 1.
  task automatic start_op(input operand_type_t t, input logic [15:0] p,
                          input logic [7:0] xv, input logic [7:0] yv);
    op_type = t;
    pc      = p;
    x       = xv;
    y       = yv;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {15'd0, busy1}, 16'd0);
    check({tag, "_rd"},   {15'd0, rd1},   16'd0);
    check({tag, "_addr"}, addr1,          16'h0000);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    op_type = IMPLIED;
    pc      = 16'h0000;
    x       = 8'h00;
    y       = 8'h00;

    mem[16'h0200] = 8'h42;
    mem[16'h0300] = 8'hF8;
    mem[16'h0400] = 8'hF0; mem[16'h0401] = 8'h12;
    mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h30;
    mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12; mem[16'h3100] = 8'h99;
    mem[16'h0600] = 8'hFF; mem[16'h00FF] = 8'h80; mem[16'h0000] = 8'h40;
    mem[16'h0100] = 8'h77;
    mem[16'h0700] = 8'h20; mem[16'h0024] = 8'hCD; mem[16'h0025] = 8'hAB;
    mem[16'h0800] = 8'h10; mem[16'h0801] = 8'h20;

    // Reset state
    tick(); tick();
    check_idle("rst");
    check("rst_done", {15'd0, done1}, 16'd0);
    check("rst_ea", ea1, 16'h0000);
    check("rst_opr", {8'd0, opr1}, 16'h0000);
    check("rst_pcn", pcn1, 16'h0000);
    check("rst_pcx", {15'd0, pcx1}, 16'd0);
    rst = 1'b0;
    tick();

    // IMMEDIATE at 0x0200; i_start during DONE must be ignored
    start_op(IMMEDIATE, 16'h0200, 8'h00, 8'h00);
    check("imm_c1_rd", {15'd0, rd1}, 16'd1);
    check("imm_c1_addr", addr1, 16'h0200);
    check("imm_c1_busy", {15'd0, busy1}, 16'd1);
    check("imm_c1_done", {15'd0, done1}, 16'd0);
    tick();
    check("imm_c2_done", {15'd0, done1}, 16'd1);
    check("imm_opr", {8'd0, opr1}, 16'h0042);
    check("imm_pcn", pcn1, 16'h0201);
    check("imm_ea", ea1, 16'h0200);
    check("imm_c2_rd", {15'd0, rd1}, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("imm_start_in_done_busy", {15'd0, busy1}, 16'd0);
    check("imm_after_done", {15'd0, done1}, 16'd0);
    tick();
    check("imm_start_in_done_still_idle", {15'd0, busy1}, 16'd0);

    // IMPLIED: no read, done in cycle 1
    start_op(IMPLIED, 16'h1234, 8'h00, 8'h00);
    check("imp_done", {15'd0, done1}, 16'd1);
    check("imp_rd", {15'd0, rd1}, 16'd0);
    check("imp_ea", ea1, 16'h0000);
    check("imp_pcn", pcn1, 16'h1234);
    tick();

    // ZP_X wraps in page zero: 0xF8 + 0x10 -> 0x0008
    start_op(ZP_X, 16'h0300, 8'h10, 8'h00);
    check("zpx_addr", addr1, 16'h0300);
    tick();
    check("zpx_done", {15'd0, done1}, 16'd1);
    check("zpx_ea", ea1, 16'h0008);
    check("zpx_pcx", {15'd0, pcx1}, 16'd0);
    check("zpx_pcn", pcn1, 16'h0301);
    tick();

    // ABSOLUTE_Y with page cross, both penalty settings
    start_op(ABSOLUTE_Y, 16'h0400, 8'h00, 8'h20);
    check("absy_c1_addr", addr1, 16'h0400);
    tick();
    check("absy_c2_addr", addr1, 16'h0401);
    check("absy_c2_rd", {15'd0, rd1}, 16'd1);
    tick();
    check("absy_p1_c3_done", {15'd0, done1}, 16'd0);
    check("absy_p1_c3_busy", {15'd0, busy1}, 16'd1);
    check("absy_p1_fixup_rd", {15'd0, rd1}, 16'd0);
    check("absy_p1_fixup_addr", addr1, 16'h0000);
    check("absy_p0_c3_done", {15'd0, done0}, 16'd1);
    check("absy_p0_ea", ea0, 16'h1310);
    check("absy_p0_pcx", {15'd0, pcx0}, 16'd1);
    tick();
    check("absy_p1_c4_done", {15'd0, done1}, 16'd1);
    check("absy_p1_ea", ea1, 16'h1310);
    check("absy_p1_pcx", {15'd0, pcx1}, 16'd1);
    check("absy_p1_pcn", pcn1, 16'h0402);
    check("absy_p0_c4_idle", {15'd0, busy0}, 16'd0);
    tick();

    // INDIRECT with NMOS page-wrap: pointer 0x30FF -> 0x30FF, 0x3000
    start_op(INDIRECT, 16'h0500, 8'h00, 8'h00);
    check("ind_c1_addr", addr1, 16'h0500);
    tick();
    check("ind_c2_addr", addr1, 16'h0501);
    tick();
    check("ind_c3_addr", addr1, 16'h30FF);
    tick();
    check("ind_c4_addr", addr1, 16'h3000);
    tick();
    check("ind_done", {15'd0, done1}, 16'd1);
    check("ind_ea", ea1, 16'h1234);
    check("ind_pcn", pcn1, 16'h0502);
    tick();

    // INDEX_Y_INDIRECT, z=0xFF: pointer reads 0x00FF then 0x0000
    start_op(INDEX_Y_INDIRECT, 16'h0600, 8'h00, 8'h05);
    check("iy_c1_addr", addr1, 16'h0600);
    tick();
    check("iy_c2_addr", addr1, 16'h00FF);
    tick();
    check("iy_c3_addr", addr1, 16'h0000);
    tick();
    check("iy_done", {15'd0, done1}, 16'd1);
    check("iy_ea", ea1, 16'h4085);
    check("iy_pcx", {15'd0, pcx1}, 16'd0);
    check("iy_pcn", pcn1, 16'h0601);
    tick();

    // INDEX_X_INDIRECT: z=0x20, x=4 -> pointer 0x0024/0x0025
    start_op(INDEX_X_INDIRECT, 16'h0700, 8'h04, 8'h00);
    tick();
    check("ix_c2_addr", addr1, 16'h0024);
    tick();
    check("ix_c3_addr", addr1, 16'h0025);
    tick();
    check("ix_done", {15'd0, done1}, 16'd1);
    check("ix_ea", ea1, 16'hABCD);
    check("ix_pcn", pcn1, 16'h0701);
    tick();

    // ABSOLUTE_X without page cross: done in cycle 3 even with penalty
    start_op(ABSOLUTE_X, 16'h0800, 8'h05, 8'h00);
    tick();
    tick();
    check("absx_done", {15'd0, done1}, 16'd1);
    check("absx_ea", ea1, 16'h2015);
    check("absx_pcx", {15'd0, pcx1}, 16'd0);
    check("absx_pcn", pcn1, 16'h0802);
    tick();

    // Reset during PTR_LO, with i_start raised alongside
    start_op(INDEX_Y_INDIRECT, 16'h0600, 8'h00, 8'h05);
    tick();
    check("rstmid_in_ptr_lo", addr1, 16'h00FF);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_idle("rstmid");
    check("rstmid_done", {15'd0, done1}, 16'd0);
    check("rstmid_ea", ea1, 16'h0000);
    check("rstmid_pcn", pcn1, 16'h0000);
    tick();
    check("rstmid_stays_idle", {15'd0, busy1}, 16'd0);

    // Undefined operand type behaves as IMPLIED
    start_op(operand_type_t'(4'd14), 16'h0ABC, 8'h00, 8'h00);
    check("undef_done", {15'd0, done1}, 16'd1);
    check("undef_rd", {15'd0, rd1}, 16'd0);
    check("undef_pcn", pcn1, 16'h0ABC);
    check("undef_ea", ea1, 16'h0000);
    tick();
    check("undef_back_idle", {15'd0, busy1}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
